// File: rtl/cpu_pkg.sv
// Shared definitions for the register-file write-port arbiter.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        STEAL
    } arb_state_e;

    localparam logic [4:0] XZR = 5'd31;
    localparam int unsigned DATA_W = 64;

endpackage

// File: rtl/pending_entry_reg.sv
// One-entry holding register for a displaced long-latency result.
module pending_entry_reg #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             clear,
    input  logic [4:0]       in_rd,
    input  logic [WIDTH-1:0] in_data,
    output logic             valid,
    output logic [4:0]       rd,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            rd    <= 5'd0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            rd    <= in_rd;
            data  <= in_data;
        end
    end

endmodule

// File: rtl/regwrite_port_arbiter.sv
// Shares the register-file write port between pipeline writeback and a
// long-latency unit; writeback wins, displaced results are buffered and drained.
module regwrite_port_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH        = DATA_W,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wb_regwrite,
    input  logic [4:0]       wb_rd,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             lu_valid,
    input  logic [4:0]       lu_rd,
    input  logic [WIDTH-1:0] lu_data,
    output logic             lu_ready,
    output logic             pipe_stall,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [WIDTH-1:0] rf_wdata,
    output logic             pending_valid,
    output logic [4:0]       pending_rd,
    output logic             dropped
);

    localparam int unsigned AgeW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

    arb_state_e        state_q;
    logic [AgeW-1:0]   age_q;
    logic              pipe_stall_q;
    logic              dropped_q;

    logic              pend_valid;
    logic [4:0]        pend_rd;
    logic [WIDTH-1:0]  pend_data;

    logic              steal;
    logic              wbw;
    logic              lu_acc;
    logic              pend_kill;
    logic              lu_kill;
    logic              drain;
    logic              buf_load;
    logic              buf_clear;
    logic              we_int;

    assign steal    = (state_q == STEAL);
    assign lu_ready = ~pend_valid;
    assign wbw      = wb_regwrite && (wb_rd != XZR) && !steal;
    // XZR results are accepted but never reach the buffer or the port.
    assign lu_acc   = lu_valid && lu_ready && (lu_rd != XZR);

    assign pend_kill = wbw && pend_valid && (wb_rd == pend_rd);
    assign lu_kill   = wbw && lu_acc && (lu_rd == wb_rd);
    assign drain     = pend_valid && !wbw && !steal;
    assign buf_load  = wbw && lu_acc && !lu_kill;
    assign buf_clear = steal || drain || pend_kill;

    pending_entry_reg #(
        .WIDTH(WIDTH)
    ) u_pending (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (buf_load),
        .clear  (buf_clear),
        .in_rd  (lu_rd),
        .in_data(lu_data),
        .valid  (pend_valid),
        .rd     (pend_rd),
        .data   (pend_data)
    );

    always_comb begin
        we_int   = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = '0;
        if (steal || (pend_valid && !wbw)) begin
            we_int   = 1'b1;
            rf_waddr = pend_rd;
            rf_wdata = pend_data;
        end else if (wbw) begin
            we_int   = 1'b1;
            rf_waddr = wb_rd;
            rf_wdata = wb_data;
        end else if (lu_acc) begin
            we_int   = 1'b1;
            rf_waddr = lu_rd;
            rf_wdata = lu_data;
        end
    end

    // Reset must suppress the write even though the port is combinational.
    assign rf_we = we_int && reset_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            age_q        <= '0;
            pipe_stall_q <= 1'b0;
            dropped_q    <= 1'b0;
        end else begin
            dropped_q <= pend_kill || lu_kill;
            unique case (state_q)
                IDLE: begin
                    pipe_stall_q <= 1'b0;
                    age_q        <= '0;
                    if (buf_load) begin
                        state_q <= HELD;
                    end
                end
                HELD: begin
                    if (drain || pend_kill) begin
                        state_q <= IDLE;
                        age_q   <= '0;
                    end else if (age_q == AgeW'(STARVE_LIMIT - 1)) begin
                        state_q      <= STEAL;
                        pipe_stall_q <= 1'b1;
                    end else begin
                        age_q <= age_q + AgeW'(1);
                    end
                end
                STEAL: begin
                    state_q      <= IDLE;
                    age_q        <= '0;
                    pipe_stall_q <= 1'b0;
                end
                default: begin
                    state_q      <= IDLE;
                    age_q        <= '0;
                    pipe_stall_q <= 1'b0;
                end
            endcase
        end
    end

    assign pipe_stall    = pipe_stall_q;
    assign dropped       = dropped_q;
    assign pending_valid = pend_valid;
    assign pending_rd    = pend_rd;

endmodule
